// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: launch, branch resolution, halt and a
// writable 16-entry branch-target table.
module fetch_ctrl #(
  parameter logic [9:0] PROG0_BASE = 10'd0,
  parameter logic [9:0] PROG1_BASE = 10'd128,
  parameter logic [9:0] PROG2_BASE = 10'd256,
  parameter logic [9:0] PROG3_BASE = 10'd384
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  ProgSel,
  input  logic [9:0]  PC,
  input  logic        Halt,
  input  logic        BranchReq,
  input  logic        BranchRel,
  input  logic        BranchTaken,
  input  logic [4:0]  BranchField,
  input  logic        LutWe,
  input  logic [3:0]  LutAddr,
  input  logic [9:0]  LutData,
  output logic        Jen,
  output logic [9:0]  Jump,
  output logic        Running,
  output logic        Done,
  output logic [15:0] RunCycles
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LAUNCH,
    RUN,
    DONE
  } state_t;

  state_t      state;
  state_t      stateNxt;
  logic [1:0]  progSelQ;
  logic [15:0] runCycles;
  logic [9:0]  lut [16];
  logic [9:0]  baseAddr;
  logic [9:0]  relTarget;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      progSelQ  <= 2'd0;
      runCycles <= 16'd0;
    end else begin
      state <= stateNxt;
      if (state == ARM && !Start)
        progSelQ <= ProgSel;
      if (state == LAUNCH)
        runCycles <= 16'd0;
      else if (state == RUN && runCycles != 16'hFFFF)
        runCycles <= runCycles + 16'd1;
    end
  end

  // Read side sees the pre-edge contents, so same-cycle writes return old data
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++)
        lut[i] <= 10'd0;
    end else if (LutWe) begin
      lut[LutAddr] <= LutData;
    end
  end

  always_comb begin
    baseAddr = PROG0_BASE;
    unique case (progSelQ)
      2'd0: baseAddr = PROG0_BASE;
      2'd1: baseAddr = PROG1_BASE;
      2'd2: baseAddr = PROG2_BASE;
      2'd3: baseAddr = PROG3_BASE;
    endcase
  end

  assign relTarget = PC + {{5{BranchField[4]}}, BranchField};

  always_comb begin
    stateNxt = state;
    Jen      = 1'b1;
    Jump     = PC;
    unique case (state)
      IDLE: if (Start) stateNxt = ARM;
      ARM:  if (!Start) stateNxt = LAUNCH;
      LAUNCH: begin
        Jump     = baseAddr;
        stateNxt = RUN;
      end
      RUN: begin
        if (Start) begin
          stateNxt = ARM;
        end else if (Halt) begin
          stateNxt = DONE;
        end else begin
          Jen = BranchReq & BranchTaken;
          if (BranchReq)
            Jump = BranchRel ? relTarget : lut[BranchField[3:0]];
        end
      end
      DONE: if (Start) stateNxt = ARM;
      default: stateNxt = IDLE;
    endcase
  end

  assign Running   = (state == RUN);
  assign Done      = (state == DONE);
  assign RunCycles = runCycles;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the program counter. It holds the PC while no program is running. It launches one of four programs at a selectable base address when the Start handshake completes, and resolves branches into the counter's jump-enable/jump-target pair. It also stops the machine on a halt instruction and reports completion with Done. It sits between the decoder/ALU flags and ProgCtr, and it owns a small writable branch-target lookup table.

## Interface
- PROG0_BASE, 10'd0: start address of program 0
- PROG1_BASE, 10'd128: start address of program 1
- PROG2_BASE, 10'd256: start address of program 2
- PROG3_BASE, 10'd384: start address of program 3
- Clk  in  1  single clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high; forces IDLE, clears LUT and counters
- Start  in  1  launch request; program begins after Start falls
- ProgSel  in  2  program select, sampled in the ARM→LAUNCH transition
- PC  in  10  current PC from ProgCtr
- Halt  in  1  decoded halt instruction at PC
- BranchReq  in  1  decoded branch instruction at PC
- BranchRel  in  1  1 = relative branch, 0 = absolute branch via LUT
- BranchTaken  in  1  ALU condition flag
- BranchField  in  5  relative: signed offset; absolute: LUT index in [3:0], bit 4 ignored
- LutWe  in  1  LUT write enable
- LutAddr  in  4  LUT write address
- LutData  in  10  LUT write data
- Jen  out  1  jump enable to ProgCtr
- Jump  out  10  jump target to ProgCtr
- Running  out  1  high only in RUN
- Done  out  1  high only in DONE
- RunCycles  out  16  RUN cycles of the current/last program, saturating

## Operation
ProgCtr contract: on each rising edge, if Jen is high then PC loads Jump, otherwise PC increments.

State machine, registered:
- IDLE: entered on Reset. Start=1 → ARM.
- ARM: Start=1 → stay in ARM. Start=0 → LAUNCH, with ProgSel latched.
- LAUNCH: Jen=1, Jump=base of latched ProgSel. Unconditionally → RUN; RunCycles cleared to 0.
- RUN:
  - Halt=1 → DONE. Jen=1, Jump=PC.
  - Otherwise Jen = BranchReq & BranchTaken.
  - Relative branch: Jump = PC + sign-extend(BranchField) mod 1024.
  - Absolute branch: Jump = LUT[BranchField[3:0]].
  - No jump: Jump = PC (don't-care while Jen=0).
  - Start=1 → ARM (abort).
  - RunCycles increments each RUN cycle and saturates at 16'hFFFF.
- DONE: Start=1 → ARM. Otherwise stay in DONE.

Outputs in non-RUN states:
- IDLE, ARM, DONE: Jen=1, Jump=PC, so PC holds.
- LAUNCH: Jen and Jump as defined above.

Priority in RUN:
1. Start
2. Halt
3. Branch
4. Increment

When Start wins in RUN, Jen=1 and Jump=PC for that cycle.

LUT:
- 16×10 registers, cleared by Reset.
- Write on rising edge when LutWe=1, in any state.
- Read is combinational from the registered array. A write and a read of the same entry in one cycle returns the old value.

Arithmetic: offsets span -16..+15. Relative targets wrap modulo 1024 (e.g. PC=3, offset -5 → 1022).

## Timing
- Reset values: state IDLE, Running=0, Done=0, RunCycles=0, all LUT entries 0. Jen=1, Jump=PC.
- Reset is asynchronous and takes effect mid-program without waiting for a clock edge.
- Jen and Jump are combinational from state and current inputs (Mealy in RUN). ProgCtr applies them at the next edge.
- Launch latency: edge k samples Start=0 in ARM. LAUNCH runs during cycle k→k+1. At edge k+1, PC=base and state=RUN. The instruction at base executes in the first RUN cycle.
- Branch latency: a taken branch at PC=p in cycle n gives PC=target after edge n+1.
- Halt at PC=h: Done and Running change at the next edge. PC stays h indefinitely.
- RunCycles equals the number of RUN cycles, including the halt cycle.

## Test plan
- Reset while Start=0, then 5 clocks → PC held at its value, Jen=1, Running=0, Done=0, RunCycles=0.
- Start=1 for 2 cycles, ProgSel=2, then Start=0 → one LAUNCH cycle with Jump=256, Jen=1. PC=256 with Running=1, then PC=257, 258.
- In RUN at PC=260: relative branch with BranchField=5'b11011 (-5) and BranchTaken=1 → PC=255. Same branch with BranchTaken=0 → PC=261. From PC=3 with offset -5 → PC=1022.
- Write LUT[7]=10'd600 during IDLE. In RUN, absolute branch with BranchField=7 and BranchTaken=1 → PC=600. A same-cycle write of LUT[7]=700 with the branch still jumps to 600.
- Halt and BranchReq/BranchTaken together at PC=300 → DONE, PC stays 300, Done=1, Running=0, RunCycles equals the RUN cycle count. Start=1 then 0 relaunches.
- Assert Reset asynchronously mid-RUN (between edges) → Running=0 and state IDLE immediately, LUT cleared, RunCycles=0.
